// File: rtl/clk_period_monitor.sv
// Measures the period of a slow monitored clock in clk_in cycles and
// reports lock, loss-of-clock and a saturating error count.
// Ports: clk_in, rst_n, clk_mon in; period, period_valid, locked,
//        clk_lost, err_count out (all registered).
module clk_period_monitor #(
  parameter int CNT_W          = 16,
  parameter int NOMINAL_PERIOD = 25176,
  parameter int TOLERANCE      = 64,
  parameter int LOCK_COUNT     = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clk_mon,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             clk_lost,
  output logic [7:0]       err_count
);

  localparam int GR_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] P_MIN =
    CNT_W'(NOMINAL_PERIOD - TOLERANCE);
  localparam logic [CNT_W-1:0] P_MAX =
    CNT_W'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [GR_W-1:0] GR_LOCK = GR_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_LOCKED,
    S_LOST
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GR_W-1:0]  good_q, good_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;
  logic [7:0]       err_q, err_d;

  logic             edge_det;
  logic             timeout;
  logic             in_range;
  logic [CNT_W-1:0] p_meas;
  logic [GR_W-1:0]  good_inc;
  logic [7:0]       err_inc;

  assign edge_det = sync2_q & ~prev_q;
  assign p_meas   = cnt_q + CNT_W'(1);
  assign in_range = (p_meas >= P_MIN) && (p_meas <= P_MAX);
  // An edge landing on the timeout cycle takes priority.
  assign timeout  = (cnt_q == P_MAX) && !edge_det;
  assign good_inc = good_q + GR_W'(1);
  assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    pv_d     = 1'b0;
    err_d    = err_q;
    if (edge_det)
      cnt_d = '0;
    else if (cnt_q == {CNT_W{1'b1}})
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        // First edge only arms the counter.
        if (edge_det) begin
          state_d = S_MEASURE;
        end else if (timeout) begin
          state_d = S_LOST;
          err_d   = err_inc;
        end
      end
      S_MEASURE: begin
        if (edge_det) begin
          period_d = p_meas;
          pv_d     = 1'b1;
          if (in_range) begin
            if (good_inc == GR_LOCK) begin
              state_d = S_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            good_d = '0;
            err_d  = err_inc;
          end
        end else if (timeout) begin
          state_d = S_LOST;
          err_d   = err_inc;
        end
      end
      S_LOCKED: begin
        if (edge_det) begin
          period_d = p_meas;
          pv_d     = 1'b1;
          if (!in_range) begin
            state_d = S_MEASURE;
            good_d  = '0;
            err_d   = err_inc;
          end
        end else if (timeout) begin
          state_d = S_LOST;
          err_d   = err_inc;
        end
      end
      S_LOST: begin
        // Interval ending here spans the outage; not a measurement.
        if (edge_det) begin
          state_d = S_MEASURE;
          good_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    locked_d = (state_d == S_LOCKED);
    lost_d   = (state_d == S_LOST);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      sync1_q  <= clk_mon;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
      err_q    <= err_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign clk_lost     = lost_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Randomized bench for clk_period_monitor against a per-interval model.
// Drives clk_mon rises on clk_in negedges so intervals are exact.
module tb_clk_period_monitor;

  localparam int NOM = 100;
  localparam int TOL = 4;
  localparam int LCK = 4;
  localparam int CW  = 16;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic          clk_mon = 1'b0;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          clk_lost;
  logic [7:0]    err_count;

  clk_period_monitor #(
    .CNT_W(CW), .NOMINAL_PERIOD(NOM),
    .TOLERANCE(TOL), .LOCK_COUNT(LCK)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .clk_mon(clk_mon),
    .period(period), .period_valid(period_valid),
    .locked(locked), .clk_lost(clk_lost),
    .err_count(err_count)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  int pv_seen = 0;
  bit lost_seen = 0;
  int since_rise = 0;

  always @(negedge clk_in) begin
    if (period_valid) pv_seen++;
    if (clk_lost) lost_seen = 1;
  end

  // Model: 0 idle, 1 measure, 2 locked, 3 lost
  int m_state, m_good, m_err, m_period, m_pv;

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_good = 0; m_err = 0; m_period = 0;
  endtask

  // One rising edge ending an interval of p clk_in cycles.
  task automatic model_edge(input int p);
    bit inr;
    inr = (p >= NOM - TOL) && (p <= NOM + TOL);
    // No edge by count NOM+TOL means timeout fired earlier.
    if (m_state != 3 && p >= NOM + TOL + 2) begin
      m_state = 3;
      m_err = sat(m_err);
    end
    case (m_state)
      0: m_state = 1;
      3: begin m_state = 1; m_good = 0; end
      1: begin
        m_period = p; m_pv++;
        if (inr) begin
          m_good++;
          if (m_good == LCK) begin m_state = 2; m_good = 0; end
        end else begin
          m_good = 0; m_err = sat(m_err);
        end
      end
      default: begin
        m_period = p; m_pv++;
        if (!inr) begin
          m_state = 1; m_good = 0; m_err = sat(m_err);
        end
      end
    endcase
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
    since_rise += n;
  endtask

  task automatic drive_rise(input int p);
    int h;
    h = p / 2;
    if (since_rise >= h) clk_mon = 1'b0;
    for (int i = since_rise + 1; i <= p; i++) begin
      @(negedge clk_in);
      if (i == h) clk_mon = 1'b0;
      if (i == p) clk_mon = 1'b1;
    end
    since_rise = 0;
    model_edge(p);
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
    since_rise = 0;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_mon = 1'b0;
    repeat (3) @(negedge clk_in);
    total++;
    if ({period, period_valid, locked, clk_lost, err_count} !== '0) begin
      bad++;
      $display("FAIL reset_outs got p=%0d v=%0b l=%0b lost=%0b e=%0d want 0",
               period, period_valid, locked, clk_lost, err_count);
    end
    release_reset();
  endtask

  task automatic test_lock();
    for (int e = 1; e <= 6; e++) begin
      drive_rise(e == 1 ? 20 : NOM);
      wait_cyc(5);
      total++;
      if (pv_seen !== m_pv || period !== CW'(m_period)) begin
        bad++;
        $display("FAIL lock_period e%0d got v=%0d p=%0d want v=%0d p=%0d",
                 e, pv_seen, period, m_pv, m_period);
      end
      total++;
      if (locked !== (e >= 5) || locked !== (m_state == 2)) begin
        bad++;
        $display("FAIL lock_state e%0d got %0b want %0b", e, locked, e >= 5);
      end
      total++;
      if (err_count !== 8'd0) begin
        bad++;
        $display("FAIL lock_err e%0d got %0d want 0", e, err_count);
      end
    end
  endtask

  task automatic test_window();
    int ps[4] = '{96, 104, 95, 105};
    int el[4] = '{1, 1, 0, 0};
    int ee[4] = '{0, 0, 1, 2};
    for (int i = 0; i < 4; i++) begin
      drive_rise(ps[i]);
      wait_cyc(5);
      total++;
      if (period !== CW'(ps[i]) || pv_seen !== m_pv) begin
        bad++;
        $display("FAIL win_period %0d got p=%0d v=%0d want v=%0d",
                 ps[i], period, pv_seen, m_pv);
      end
      total++;
      if (locked !== el[i][0] || err_count !== 8'(ee[i])
          || err_count !== 8'(m_err)) begin
        bad++;
        $display("FAIL win_state %0d got l=%0b e=%0d want l=%0b e=%0d",
                 ps[i], locked, err_count, el[i], ee[i]);
      end
    end
  endtask

  task automatic test_loss_recovery();
    int e0, exp_err;
    for (int i = 0; i < 5; i++) drive_rise(NOM);
    wait_cyc(5);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL loss_prelock got %0b want 1", locked);
    end
    e0 = err_count;
    exp_err = sat(m_err);
    clk_mon = 1'b0;
    wait_cyc(95);
    total++;
    if (clk_lost !== 1'b0) begin
      bad++;
      $display("FAIL loss_early got %0b want 0", clk_lost);
    end
    wait_cyc(15);
    total++;
    if (clk_lost !== 1'b1 || locked !== 1'b0
        || err_count !== 8'(exp_err)) begin
      bad++;
      $display("FAIL loss_set got lost=%0b l=%0b e=%0d want 1 0 %0d (was %0d)",
               clk_lost, locked, err_count, exp_err, e0);
    end
    wait_cyc(1000);
    total++;
    if (err_count !== 8'(exp_err) || clk_lost !== 1'b1) begin
      bad++;
      $display("FAIL loss_hold got e=%0d lost=%0b want %0d 1",
               err_count, clk_lost, exp_err);
    end
    drive_rise(since_rise + 40);
    wait_cyc(5);
    total++;
    if (clk_lost !== 1'b0 || pv_seen !== m_pv
        || err_count !== 8'(m_err)) begin
      bad++;
      $display("FAIL recov_first got lost=%0b v=%0d e=%0d want 0 %0d %0d",
               clk_lost, pv_seen, err_count, m_pv, m_err);
    end
    for (int i = 1; i <= 4; i++) begin
      drive_rise(NOM);
      wait_cyc(5);
      total++;
      if (locked !== (i == 4) || pv_seen !== m_pv) begin
        bad++;
        $display("FAIL recov_lock %0d got l=%0b v=%0d want %0b %0d",
                 i, locked, pv_seen, i == 4, m_pv);
      end
    end
  endtask

  task automatic test_edge_vs_timeout();
    int v0;
    v0 = pv_seen;
    lost_seen = 0;
    drive_rise(NOM + TOL + 1);
    wait_cyc(5);
    total++;
    if (period !== CW'(NOM + TOL + 1) || pv_seen !== v0 + 1) begin
      bad++;
      $display("FAIL evt_period got p=%0d v=%0d want %0d %0d",
               period, pv_seen, NOM + TOL + 1, v0 + 1);
    end
    total++;
    if (lost_seen || locked !== 1'b0 || m_state != 1
        || err_count !== 8'(m_err)) begin
      bad++;
      $display("FAIL evt_state got lost=%0b l=%0b e=%0d want 0 0 %0d",
               lost_seen, locked, err_count, m_err);
    end
  endtask

  task automatic test_random();
    int p;
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(NOM + TOL + 8, NOM - TOL - 6);
      drive_rise(p);
      wait_cyc(5);
      total++;
      if (pv_seen !== m_pv || period !== CW'(m_period)
          || locked !== (m_state == 2) || clk_lost !== 1'b0
          || err_count !== 8'(m_err)) begin
        bad++;
        $display("FAIL rand p=%0d got v=%0d p=%0d l=%0b lost=%0b e=%0d want v=%0d p=%0d st=%0d e=%0d",
                 p, pv_seen, period, locked, clk_lost, err_count,
                 m_pv, m_period, m_state, m_err);
      end
    end
  endtask

  task automatic test_saturation_reset();
    int v0;
    for (int i = 0; i < 300; i++) drive_rise((i % 2) ? 150 : 50);
    wait_cyc(5);
    total++;
    if (err_count !== 8'd255 || m_err != 255) begin
      bad++;
      $display("FAIL sat_err got %0d want 255", err_count);
    end
    drive_rise(50);
    wait_cyc(5);
    total++;
    if (err_count !== 8'd255) begin
      bad++;
      $display("FAIL sat_hold got %0d want 255", err_count);
    end
    wait_cyc(30);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({period, period_valid, locked, clk_lost, err_count} !== '0) begin
      bad++;
      $display("FAIL midreset got p=%0d v=%0b l=%0b lost=%0b e=%0d want 0",
               period, period_valid, locked, clk_lost, err_count);
    end
    clk_mon = 1'b0;
    repeat (2) @(negedge clk_in);
    release_reset();
    v0 = pv_seen;
    drive_rise(30);
    wait_cyc(5);
    total++;
    if (pv_seen !== v0 || period !== '0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL postreset_first got v=%0d p=%0d e=%0d want %0d 0 0",
               pv_seen, period, err_count, v0);
    end
    drive_rise(NOM);
    wait_cyc(5);
    total++;
    if (pv_seen !== v0 + 1 || period !== CW'(NOM)) begin
      bad++;
      $display("FAIL postreset_second got v=%0d p=%0d want %0d %0d",
               pv_seen, period, v0 + 1, NOM);
    end
  endtask

  initial begin
    m_pv = 0;
    model_reset();
    test_reset();
    test_lock();
    test_window();
    test_loss_recovery();
    test_edge_vs_timeout();
    test_random();
    test_saturation_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
